alarm_ctrl: RTL
===============

// Module: alarm_ctrl
// PURPOSE
//  Sequencer for the alarm-set counters and the alarm ringer. Debounced-clock button
//  inputs step an FSM through hour-set, minute-set and armed modes. It drives the
//  enable/setting strobes of the alarm hour/minute counters and compares the alarm
//  against the running time. Controls buzzer, snooze and ring timeout.
// PARAMETERS
//  RING_SEC    60  ring duration in tick_1s pulses before auto-stop (1..63)
//  SNOOZE_SEC  30  snooze delay in tick_1s pulses (1..63)
//  MAX_SNOOZE  3   snooze presses honoured per alarm event (0..7)
// PORTS
//  clock         in   1  divided system clock
//  reset_hour    in   1  asynchronous, active-high reset
//  tick_1s       in   1  one-clock pulse per second from the time base
//  mode_btn      in   1  raw button: advance mode
//  inc_btn       in   1  raw button: increment selected alarm field
//  snooze_btn    in   1  raw button: snooze ringing alarm
//  stop_btn      in   1  raw button: stop ringing alarm
//  arm_sw        in   1  level switch: 1 = alarm armed
//  time_hour     in   6  current time hour 0..23
//  time_min      in   6  current time minute 0..59
//  time_sec      in   6  current time second 0..59
//  alarm_hour    in   6  alarm hour counter value
//  alarm_min     in   6  alarm minute counter value
//  enable_hour   out  1  hour counter enable (1 while state==SET_H)
//  setting_hour  out  1  one-clock increment strobe to hour counter
//  enable_min    out  1  minute counter enable (1 while state==SET_M)
//  setting_min   out  1  one-clock increment strobe to minute counter
//  buzzer        out  1  1 while state==RING
//  state         out  3  FSM state encoding (debug/display)
// BEHAVIOUR
//  - Reset: state=IDLE(0); all outputs 0; ring_tmr, snooze_tmr, snooze_cnt, sync FFs = 0.
//  - Each button: 2-FF synchroniser + history FF; edge = sync2 & ~hist. Button high at
//    edge k -> edge pulse valid between edge k+1 and k+2. Held buttons yield one edge only.
//  - All outputs are registered. inc edge in SET_H/SET_M -> setting_* high exactly one
//    cycle, starting the clock after the edge pulse. inc edge in any other state: ignored.
//  - States: IDLE=0 SET_H=1 SET_M=2 ARMED=3 RING=4 SNOOZE=5; codes 6,7 -> IDLE next clock.
//  - IDLE:   mode -> SET_H; else arm_sw=1 -> ARMED.
//  - SET_H:  mode -> SET_M; inc -> setting_hour pulse.
//  - SET_M:  mode -> ARMED if arm_sw else IDLE; inc -> setting_min pulse.
//  - ARMED:  arm_sw=0 -> IDLE; mode -> SET_H; match -> RING (ring_tmr=0, snooze_cnt=0).
//    match = time_hour==alarm_hour && time_min==alarm_min && time_sec==0 && tick_1s.
//  - RING:   priority arm_sw=0 -> IDLE; stop -> ARMED; snooze && snooze_cnt<MAX_SNOOZE
//    -> SNOOZE (snooze_tmr=SNOOZE_SEC, snooze_cnt+1); ring_tmr==RING_SEC-1 on tick_1s
//    -> ARMED; otherwise ring_tmr+1 on each tick_1s. Snooze beyond MAX_SNOOZE ignored.
//  - SNOOZE: priority arm_sw=0 -> IDLE; stop -> ARMED; tick_1s && snooze_tmr==1 -> RING
//    (ring_tmr=0); else snooze_tmr-1 on tick_1s. mode/inc ignored.
//  - Simultaneous edges: mode beats inc (no strobe); stop beats snooze.
//  - Match seen outside ARMED is discarded, never queued.
//  - RING/SNOOZE -> ARMED within the same second as the match cannot retrigger:
//    match needs a tick_1s at time_sec==0.
//  - Timers are 6-bit, saturating: no wrap.
//  - Async reset mid-RING: buzzer drops immediately; FSM returns to IDLE.
// TESTING
//  T1 reset, mode x1, inc x3, mode, inc x2 -> 3 setting_hour pulses, 2 setting_min; state 1 then 2.
//  T2 ARMED, alarm 07:30; drive time 07:30:00 + tick_1s -> buzzer=1 next clock; stop -> buzzer=0, state=3.
//  T3 RING, no input, 60 ticks -> buzzer drops after 60th tick; state=3.
//  T4 RING, snooze x4 with SNOOZE_SEC ticks between -> 3 SNOOZE entries; 4th press ignored.
//  T5 mode+inc same clock in SET_H -> state=2, no setting_hour; held inc 20 clocks -> one strobe.
//  T6 reset_hour pulse mid-RING and arm_sw=0 mid-SNOOZE -> buzzer=0 asynchronously; state=0.

Source files
------------

// File: rtl/alarm_ctrl_if.sv
// Button, time and control signals between the alarm sequencer and its surroundings.
// The master side drives buttons/time/alarm values; the slave side is the sequencer.
interface alarm_ctrl_if;
  logic       tick_1s;
  logic       mode_btn;
  logic       inc_btn;
  logic       snooze_btn;
  logic       stop_btn;
  logic       arm_sw;
  logic [5:0] time_hour;
  logic [5:0] time_min;
  logic [5:0] time_sec;
  logic [5:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       enable_hour;
  logic       setting_hour;
  logic       enable_min;
  logic       setting_min;
  logic       buzzer;
  logic [2:0] state;

  modport master (
    output tick_1s, mode_btn, inc_btn, snooze_btn, stop_btn, arm_sw,
    output time_hour, time_min, time_sec, alarm_hour, alarm_min,
    input  enable_hour, setting_hour, enable_min, setting_min, buzzer, state
  );

  modport slave (
    input  tick_1s, mode_btn, inc_btn, snooze_btn, stop_btn, arm_sw,
    input  time_hour, time_min, time_sec, alarm_hour, alarm_min,
    output enable_hour, setting_hour, enable_min, setting_min, buzzer, state
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: steps through hour/minute setting and armed modes, rings the
// buzzer on an alarm match and handles snooze, stop and ring timeout.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 30,
  parameter int MAX_SNOOZE = 3
) (
  input  logic         clock,
  input  logic         reset_hour,
  alarm_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    ARMED  = 3'd3,
    RING   = 3'd4,
    SNOOZE = 3'd5
  } state_t;

  localparam logic [5:0] RING_LAST   = 6'(RING_SEC - 1);
  localparam logic [5:0] SNOOZE_LOAD = 6'(SNOOZE_SEC);
  localparam logic [2:0] MAX_CNT     = 3'(MAX_SNOOZE);
  localparam logic [5:0] TMR_MAX     = 6'h3f;

  // Button bit order: {stop, snooze, inc, mode}
  logic [3:0] btn_raw;
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] hist_reg;
  logic [3:0] btn_edge;

  assign btn_raw  = {bus.stop_btn, bus.snooze_btn, bus.inc_btn, bus.mode_btn};
  assign btn_edge = sync2_reg & ~hist_reg;

  logic mode_edge, inc_edge, snooze_edge, stop_edge;
  assign mode_edge   = btn_edge[0];
  assign inc_edge    = btn_edge[1];
  assign snooze_edge = btn_edge[2];
  assign stop_edge   = btn_edge[3];

  always_ff @(posedge clock or posedge reset_hour) begin
    if (reset_hour) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      hist_reg  <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  state_t     state_reg, state_next;
  logic [5:0] ring_tmr_reg, ring_tmr_next;
  logic [5:0] snooze_tmr_reg, snooze_tmr_next;
  logic [2:0] snooze_cnt_reg, snooze_cnt_next;
  logic       match;

  // Only a tick at second zero matches, so leaving RING/SNOOZE early never retriggers.
  assign match = (bus.time_hour == bus.alarm_hour) && (bus.time_min == bus.alarm_min) &&
                 (bus.time_sec == 6'd0) && bus.tick_1s;

  always_comb begin
    state_next      = state_reg;
    ring_tmr_next   = ring_tmr_reg;
    snooze_tmr_next = snooze_tmr_reg;
    snooze_cnt_next = snooze_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (mode_edge)       state_next = SET_H;
        else if (bus.arm_sw) state_next = ARMED;
      end
      SET_H: begin
        if (mode_edge) state_next = SET_M;
      end
      SET_M: begin
        if (mode_edge) state_next = bus.arm_sw ? ARMED : IDLE;
      end
      ARMED: begin
        if (!bus.arm_sw)    state_next = IDLE;
        else if (mode_edge) state_next = SET_H;
        else if (match) begin
          state_next      = RING;
          ring_tmr_next   = 6'd0;
          snooze_cnt_next = 3'd0;
        end
      end
      RING: begin
        if (!bus.arm_sw)    state_next = IDLE;
        else if (stop_edge) state_next = ARMED;
        else if (snooze_edge && (snooze_cnt_reg < MAX_CNT)) begin
          state_next      = SNOOZE;
          snooze_tmr_next = SNOOZE_LOAD;
          snooze_cnt_next = snooze_cnt_reg + 3'd1;
        end else if (bus.tick_1s) begin
          if (ring_tmr_reg == RING_LAST)    state_next = ARMED;
          else if (ring_tmr_reg != TMR_MAX) ring_tmr_next = ring_tmr_reg + 6'd1;
        end
      end
      SNOOZE: begin
        if (!bus.arm_sw)    state_next = IDLE;
        else if (stop_edge) state_next = ARMED;
        else if (bus.tick_1s) begin
          if (snooze_tmr_reg == 6'd1) begin
            state_next    = RING;
            ring_tmr_next = 6'd0;
          end else if (snooze_tmr_reg != 6'd0) begin
            snooze_tmr_next = snooze_tmr_reg - 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic enable_hour_reg, enable_min_reg, setting_hour_reg, setting_min_reg, buzzer_reg;

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clock or posedge reset_hour) begin
    if (reset_hour) begin
      state_reg        <= IDLE;
      ring_tmr_reg     <= '0;
      snooze_tmr_reg   <= '0;
      snooze_cnt_reg   <= '0;
      enable_hour_reg  <= 1'b0;
      enable_min_reg   <= 1'b0;
      setting_hour_reg <= 1'b0;
      setting_min_reg  <= 1'b0;
      buzzer_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ring_tmr_reg     <= ring_tmr_next;
      snooze_tmr_reg   <= snooze_tmr_next;
      snooze_cnt_reg   <= snooze_cnt_next;
      enable_hour_reg  <= (state_next == SET_H);
      enable_min_reg   <= (state_next == SET_M);
      setting_hour_reg <= (state_reg == SET_H) && inc_edge && !mode_edge;
      setting_min_reg  <= (state_reg == SET_M) && inc_edge && !mode_edge;
      buzzer_reg       <= (state_next == RING);
    end
  end

  assign bus.state        = state_reg;
  assign bus.enable_hour  = enable_hour_reg;
  assign bus.enable_min   = enable_min_reg;
  assign bus.setting_hour = setting_hour_reg;
  assign bus.setting_min  = setting_min_reg;
  assign bus.buzzer       = buzzer_reg;

endmodule
